// File: rtl/i2s_tx_scheduler.sv
// rtl/i2s_tx_scheduler.sv - I2S DAC data scheduler: per-frame audio/sidetone arbitration and MSB-first serialiser
module i2s_tx_scheduler #(
  parameter int DATA_W      = 16,
  parameter int SLOT_BITS   = 32,
  parameter int HANG_FRAMES = 64
) (
  input  logic              CLK_IN,
  input  logic              reset_n,
  input  logic              Bfall,
  input  logic              LRfall,
  input  logic              LRrise,
  input  logic              aud_valid,
  input  logic [DATA_W-1:0] aud_l,
  input  logic [DATA_W-1:0] aud_r,
  output logic              aud_ready,
  input  logic              st_en,
  input  logic              st_valid,
  input  logic [DATA_W-1:0] st_l,
  input  logic [DATA_W-1:0] st_r,
  output logic              st_ready,
  output logic              DOUT,
  output logic [1:0]        active_src,
  output logic [7:0]        underrun_cnt
);

  localparam int CNT_W = $clog2(SLOT_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AUDIO = 2'd1,
    S_TONE  = 2'd2,
    S_HANG  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        hang_q, hang_d;
  logic [DATA_W-1:0] held_l_q, held_l_d;
  logic [DATA_W-1:0] held_r_q, held_r_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              slot_start_q, slot_start_d;
  logic              slot_right_q, slot_right_d;
  logic              dout_q, dout_d;
  logic [7:0]        under_q, under_d;
  logic              aud_ready_q, aud_ready_d;
  logic              st_ready_q, st_ready_d;

  logic              take_aud;
  logic              take_st;
  logic              miss;
  logic              audio_dec;
  logic [DATA_W-1:0] slot_word;

  // Frame decision at LRfall, slot arming at LR edges, and bit shifting on BCLK falls
  always_comb begin
    state_d      = state_q;
    hang_d       = hang_q;
    held_l_d     = held_l_q;
    held_r_d     = held_r_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    slot_start_d = slot_start_q;
    slot_right_d = slot_right_q;
    dout_d       = dout_q;
    under_d      = under_q;
    aud_ready_d  = 1'b0;
    st_ready_d   = 1'b0;
    take_aud     = 1'b0;
    take_st      = 1'b0;
    miss         = 1'b0;
    audio_dec    = 1'b0;
    slot_word    = '0;

    if (LRfall) begin
      case (state_q)
        S_TONE: begin
          if (st_en) begin
            if (st_valid) take_st = 1'b1;
            else          miss    = 1'b1;
          end else begin
            state_d = S_HANG;
            hang_d  = 8'(HANG_FRAMES - 1);
          end
        end
        S_HANG: begin
          if (st_en && st_valid) begin
            state_d = S_TONE;
            take_st = 1'b1;
          end else if (hang_q != 8'd0) begin
            hang_d = hang_q - 8'd1;
          end else begin
            audio_dec = 1'b1;
          end
        end
        default: audio_dec = 1'b1;
      endcase

      // Audio-mode selection; a keyed sidetone with data always wins the frame
      if (audio_dec) begin
        state_d = S_AUDIO;
        if (st_en && st_valid) begin
          state_d = S_TONE;
          take_st = 1'b1;
        end else if (aud_valid) begin
          take_aud = 1'b1;
        end else begin
          miss = 1'b1;
        end
      end

      held_l_d     = take_st ? st_l : (take_aud ? aud_l : '0);
      held_r_d     = take_st ? st_r : (take_aud ? aud_r : '0);
      aud_ready_d  = take_aud;
      st_ready_d   = take_st;
      if (miss && under_q != 8'hFF) under_d = under_q + 8'd1;
      slot_start_d = 1'b1;
      slot_right_d = 1'b0;
    end else if (LRrise && state_q != S_IDLE) begin
      slot_start_d = 1'b1;
      slot_right_d = 1'b1;
    end else if (Bfall) begin
      if (slot_start_q) begin
        slot_word    = slot_right_q ? held_r_q : held_l_q;
        shift_d      = slot_word;
        dout_d       = slot_word[DATA_W-1];
        bit_cnt_d    = CNT_W'(1);
        slot_start_d = 1'b0;
      end else if (bit_cnt_q < CNT_W'(DATA_W)) begin
        dout_d    = shift_q[DATA_W-2];
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        dout_d = 1'b0;
      end
    end
  end

  // State and datapath registers; reset drops DOUT immediately and forgets frame alignment
  always_ff @(posedge CLK_IN or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      hang_q       <= '0;
      held_l_q     <= '0;
      held_r_q     <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      slot_start_q <= 1'b0;
      slot_right_q <= 1'b0;
      dout_q       <= 1'b0;
      under_q      <= '0;
      aud_ready_q  <= 1'b0;
      st_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hang_q       <= hang_d;
      held_l_q     <= held_l_d;
      held_r_q     <= held_r_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      slot_start_q <= slot_start_d;
      slot_right_q <= slot_right_d;
      dout_q       <= dout_d;
      under_q      <= under_d;
      aud_ready_q  <= aud_ready_d;
      st_ready_q   <= st_ready_d;
    end
  end

  assign DOUT         = dout_q;
  assign active_src   = state_q;
  assign underrun_cnt = under_q;
  assign aud_ready    = aud_ready_q;
  assign st_ready     = st_ready_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb/tb_i2s_tx_scheduler.sv - scoreboard bench for i2s_tx_scheduler with a frame-level reference model
module tb_i2s_tx_scheduler;

  localparam int DATA_W      = 16;
  localparam int SLOT_BITS   = 32;
  localparam int HANG_FRAMES = 4;
  localparam int FRAME       = 128;

  logic              CLK_IN;
  logic              reset_n;
  logic              Bfall, LRfall, LRrise;
  logic              aud_valid, st_en, st_valid;
  logic [DATA_W-1:0] aud_l, aud_r, st_l, st_r;
  logic              aud_ready, st_ready, DOUT;
  logic [1:0]        active_src;
  logic [7:0]        underrun_cnt;

  i2s_tx_scheduler #(
    .DATA_W(DATA_W), .SLOT_BITS(SLOT_BITS), .HANG_FRAMES(HANG_FRAMES)
  ) dut (
    .CLK_IN(CLK_IN), .reset_n(reset_n), .Bfall(Bfall), .LRfall(LRfall), .LRrise(LRrise),
    .aud_valid(aud_valid), .aud_l(aud_l), .aud_r(aud_r), .aud_ready(aud_ready),
    .st_en(st_en), .st_valid(st_valid), .st_l(st_l), .st_r(st_r), .st_ready(st_ready),
    .DOUT(DOUT), .active_src(active_src), .underrun_cnt(underrun_cnt)
  );

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } data_t;

  typedef struct {
    bit         ar;
    bit         sr;
    logic [1:0] src;
    logic [7:0] und;
  } rdy_t;

  data_t dq[$];
  rdy_t  rq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b1;
  logic bf_d = 1'b0;
  logic lrf_d = 1'b0;

  // reference model state: frame mode 0 idle,1 audio,2 tone,3 hang
  int m_mode = 0;
  int m_hang = 0;
  int m_under = 0;
  bit aud_taken = 1'b0;
  bit st_taken = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slot_of(input logic [15:0] v);
    return {v, 16'h0000};
  endfunction

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  // strobe generator: BCLK fall every 2 cycles, LR edges on odd cycles, 64 BCLK per frame
  initial begin
    Bfall = 1'b0; LRfall = 1'b0; LRrise = 1'b0;
    forever begin
      @(posedge CLK_IN);
      #1;
      cyc++;
      Bfall  = (cyc % 2 == 0);
      LRfall = (cyc % FRAME == FRAME - 1);
      LRrise = (cyc % FRAME == FRAME / 2 - 1);
    end
  end

  always @(posedge CLK_IN) begin
    bf_d  <= Bfall;
    lrf_d <= LRfall;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic wait_mod(input int m);
    do begin
      @(posedge CLK_IN);
      #2;
    end while (cyc % FRAME != m);
  endtask

  // frame-level rules: what the next LRfall should pick and emit
  task automatic model_frame();
    int take = 0;
    bit miss = 1'b0;
    bit aud_dec = 1'b0;
    data_t d;
    rdy_t r;
    case (m_mode)
      2: begin
        if (st_en) begin
          if (st_valid) take = 2;
          else          miss = 1'b1;
        end else begin
          m_mode = 3;
          m_hang = 1;
        end
      end
      3: begin
        if (st_en && st_valid) begin
          m_mode = 2;
          take = 2;
        end else if (m_hang < HANG_FRAMES) begin
          m_hang++;
        end else begin
          aud_dec = 1'b1;
        end
      end
      default: aud_dec = 1'b1;
    endcase
    if (aud_dec) begin
      m_mode = 1;
      if (st_en && st_valid) begin
        m_mode = 2;
        take = 2;
      end else if (aud_valid) begin
        take = 1;
      end else begin
        miss = 1'b1;
      end
    end
    if (miss && m_under < 255) m_under++;
    aud_taken = (take == 1);
    st_taken  = (take == 2);
    d.l = (take == 1) ? slot_of(aud_l) : (take == 2) ? slot_of(st_l) : 32'h0;
    d.r = (take == 1) ? slot_of(aud_r) : (take == 2) ? slot_of(st_r) : 32'h0;
    r.ar  = (take == 1);
    r.sr  = (take == 2);
    r.src = 2'(m_mode);
    r.und = 8'(m_under);
    dq.push_back(d);
    rq.push_back(r);
  endtask

  // present inputs ahead of the next LRfall; an unconsumed pair is held unchanged
  task automatic frame(input bit av, input logic [15:0] al, input logic [15:0] ar,
                       input bit sen, input bit sv, input logic [15:0] sl, input logic [15:0] sr);
    wait_mod(100);
    if (!aud_valid || aud_taken) begin
      aud_valid = av; aud_l = al; aud_r = ar;
    end
    if (!st_valid || st_taken) begin
      st_valid = sv; st_l = sl; st_r = sr;
    end
    st_en = sen;
    model_frame();
  endtask

  // monitor: ready/state after each LRfall, 64 DOUT bits per frame
  initial begin
    bit started = 1'b0;
    int nbits = 0;
    logic [31:0] wl = 32'h0;
    logic [31:0] wr = 32'h0;
    data_t d;
    rdy_t r;
    forever begin
      @(negedge CLK_IN);
      if (!reset_n) begin
        started = 1'b0;
        nbits = 0;
      end else if (mon_en) begin
        if (lrf_d) begin
          if (started) chk("frame_bits", nbits, 64);
          started = 1'b1;
          nbits = 0;
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL ready_queue: got empty expected entry");
          end else begin
            r = rq.pop_front();
            chk("aud_ready", aud_ready, r.ar);
            chk("st_ready", st_ready, r.sr);
            chk("active_src", active_src, r.src);
            chk("underrun_cnt", underrun_cnt, r.und);
          end
        end else begin
          chk("ready_quiet", {aud_ready, st_ready}, 0);
          if (!started) begin
            chk("idle_dout", DOUT, 0);
            chk("idle_src", active_src, 0);
          end
          if (bf_d && started && nbits < 64) begin
            if (nbits < 32) wl = {wl[30:0], DOUT};
            else            wr = {wr[30:0], DOUT};
            nbits++;
            if (nbits == 64) begin
              if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL data_queue: got empty expected entry");
              end else begin
                d = dq.pop_front();
                chk("left_slot", wl, d.l);
                chk("right_slot", wr, d.r);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    aud_valid = 1'b0; aud_l = '0; aud_r = '0;
    st_en = 1'b0; st_valid = 1'b0; st_l = '0; st_r = '0;
    repeat (5) @(posedge CLK_IN);
    #2;
    chk("rst_dout", DOUT, 0);
    chk("rst_aud_ready", aud_ready, 0);
    chk("rst_st_ready", st_ready, 0);
    chk("rst_src", active_src, 0);
    chk("rst_underrun", underrun_cnt, 0);
    reset_n = 1'b1;

    // known pair on the first aligned frame
    frame(1'b1, 16'hA5C3, 16'h0F0F, 1'b0, 1'b0, 16'h0, 16'h0);

    // three audio underruns
    for (int i = 0; i < 3; i++) frame(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_mod(5);
    chk("underrun_3", underrun_cnt, 3);

    // reset in the middle of a left slot carrying all ones
    frame(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_mod(16);
    chk("pre_reset_dout", DOUT, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_dout", DOUT, 0);
    chk("reset_aud_ready", aud_ready, 0);
    chk("reset_st_ready", st_ready, 0);
    chk("reset_src", active_src, 0);
    dq.delete();
    rq.delete();
    m_mode = 0; m_hang = 0; m_under = 0;
    repeat (3) @(posedge CLK_IN);
    #2;
    reset_n = 1'b1;

    // realign in audio, then a tie between audio and sidetone
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 16'h0);
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    wait_mod(5);
    chk("tie_src", active_src, 2);
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 16'h0, 16'h0);
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 16'($urandom), 16'($urandom));

    // key up: hang frames then audio resumes with the held pair
    for (int i = 0; i < HANG_FRAMES; i++) frame(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 16'h0);
    wait_mod(5);
    chk("hang_src", active_src, 3);
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 16'h0);
    wait_mod(5);
    chk("resume_src", active_src, 1);

    // re-key during hang
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0, 16'h0);
    frame(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b1, 16'($urandom), 16'($urandom));
    wait_mod(5);
    chk("rekey_src", active_src, 2);

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      frame(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
            ($urandom % 3) != 0, ($urandom % 4) != 0, 16'($urandom), 16'($urandom));
    end

    // long starvation saturates the underrun counter
    for (int i = 0; i < 300; i++) frame(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    wait_mod(FRAME - 1);
    wait_mod(FRAME - 1);
    @(negedge CLK_IN);
    #1;
    mon_en = 1'b0;
    chk("data_queue_drained", dq.size(), 0);
    chk("ready_queue_drained", rq.size(), 0);
    chk("underrun_sat", underrun_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
